// File: rtl/mem_io_bridge.sv
// Data-side memory/I/O bridge: zero-wait RAM pass-through plus a stalling
// req/ack transaction engine for the 1 KiB I/O window at the top of memory.
module mem_io_bridge #(
    parameter logic [21:0] IO_BASE_HI = 22'h3FFFFF,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    input  logic [31:0] ram_rdata,
    output logic        ram_we,
    output logic        io_req,
    output logic        io_we,
    output logic [9:0]  io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        io_timeout
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      RDATA_TO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               io_req_q, io_req_d;
    logic               io_we_q, io_we_d;
    logic [9:0]         io_addr_q, io_addr_d;
    logic [31:0]        io_wdata_q, io_wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic io_sel;
    logic access;
    logic start;
    logic cnt_last;

    assign io_sel   = (address[31:10] == IO_BASE_HI);
    assign access   = mem_read | mem_write;
    assign start    = access & io_sel;
    assign cnt_last = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over the timeout in REQ
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ:  if (io_ack || cnt_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and transaction datapath
    always_comb begin
        io_req_d   = (state_d == S_REQ);
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    io_we_d    = mem_write;
                    io_addr_d  = address[9:0];
                    io_wdata_d = write_data;
                    cnt_d      = '0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (io_ack) begin
                    rdata_d = io_we_q ? 32'h0 : io_rdata;
                end else if (cnt_last) begin
                    rdata_d   = RDATA_TO;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // CPU-facing outputs are combinational so RAM accesses cost no cycles
    assign stall     = ((state_q == S_IDLE) & start) | (state_q == S_REQ);
    assign ram_we    = mem_write & ~io_sel;
    assign read_data = (state_q == S_DONE) ? rdata_q : ram_rdata;

    assign io_req     = io_req_q;
    assign io_we      = io_we_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign io_timeout = timeout_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge with a transaction-schedule model.
module tb_mem_io_bridge;

    localparam int unsigned TIMEOUT = 15;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic        io_req;
    logic        io_we;
    logic [9:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ack;
    logic        io_timeout;

    mem_io_bridge #(.IO_BASE_HI(22'h3FFFFF), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack),
        .io_timeout (io_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: latched transaction fields, sticky timeout, expected cycle outputs
    logic [9:0]  m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic        m_timeout;
    logic        exp_stall;
    logic        exp_ram_we;
    logic        exp_io_req;
    logic        exp_done;
    logic [31:0] exp_rdata;
    logic        chk_en;
    int          stall_cnt;
    logic [31:0] done_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single per-cycle compare against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("ram_we", 32'(ram_we), 32'(exp_ram_we));
            chk("io_req", 32'(io_req), 32'(exp_io_req));
            chk("io_we", 32'(io_we), 32'(m_we));
            chk("io_addr", 32'(io_addr), 32'(m_addr));
            chk("io_wdata", io_wdata, m_wdata);
            chk("io_timeout", 32'(io_timeout), 32'(m_timeout));
            chk("read_data", read_data, exp_done ? exp_rdata : ram_rdata);
            if (stall) stall_cnt++;
            if (exp_done) done_rdata = read_data;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic ram_op(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] rdv, input logic [31:0] wdv, input logic ack);
        cyc();
        address    = a;
        mem_read   = rd;
        mem_write  = wr;
        ram_rdata  = rdv;
        write_data = wdv;
        io_ack     = ack;
        exp_stall  = 1'b0;
        exp_ram_we = wr;
        exp_io_req = 1'b0;
        exp_done   = 1'b0;
    endtask

    // One I/O access; ack_k is the REQ cycle carrying the ack (0 = never)
    task automatic io_txn(input logic [31:0] a, input logic wr, input logic both,
                          input logic [31:0] wdv, input logic [31:0] rdv, input int ack_k);
        logic timed;
        int   n;
        timed = !(ack_k >= 1 && ack_k <= int'(TIMEOUT));
        n     = timed ? int'(TIMEOUT) : ack_k;
        stall_cnt = 0;
        cyc();
        address    = a;
        mem_read   = !wr || both;
        mem_write  = wr;
        write_data = wdv;
        io_ack     = 1'b0;
        io_rdata   = 32'h0;
        ram_rdata  = 32'h0BAD_0000;
        exp_stall  = 1'b1;
        exp_ram_we = 1'b0;
        exp_io_req = 1'b0;
        exp_done   = 1'b0;
        for (int j = 1; j <= n; j++) begin
            cyc();
            io_ack     = (j == ack_k);
            io_rdata   = (j == ack_k) ? rdv : 32'h5555_0000 + 32'(j);
            ram_rdata  = 32'h0BAD_0000 + 32'(j);
            m_addr     = a[9:0];
            m_we       = wr;
            m_wdata    = wdv;
            exp_io_req = 1'b1;
        end
        cyc();
        io_ack     = 1'b0;
        exp_stall  = 1'b0;
        exp_io_req = 1'b0;
        exp_done   = 1'b1;
        exp_rdata  = timed ? 32'hFFFF_FFFF : (wr ? 32'h0 : rdv);
        if (timed) m_timeout = 1'b1;
        cyc();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exp_done  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = 32'h0;
        write_data = 32'h0; ram_rdata = 32'h0; io_rdata = 32'h0; io_ack = 1'b0;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_timeout = 1'b0;
        exp_stall = 1'b0; exp_ram_we = 1'b0; exp_io_req = 1'b0; exp_done = 1'b0;
        exp_rdata = '0; stall_cnt = 0; done_rdata = '0;
        chk_en = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;

        // RAM store then load
        ram_op(32'h0000_0010, 1'b0, 1'b1, 32'h0, 32'h1111_2222, 1'b0);
        ram_op(32'h0000_0010, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
        #1;
        chk("lit_ram_rd", read_data, 32'h1234_5678);
        chk("lit_ram_stall", 32'(stall), 32'h0);

        // I/O read, ack on 3rd REQ cycle
        io_txn(32'hFFFF_FC60, 1'b0, 1'b0, 32'h0000_0099, 32'h0000_A5A5, 3);
        chk("lit_rd_stalls", 32'(stall_cnt), 32'd4);
        chk("lit_rd_data", done_rdata, 32'h0000_A5A5);
        chk("lit_rd_addr", 32'(io_addr), 32'h060);
        chk("lit_rd_we", 32'(io_we), 32'h0);

        // I/O write, ack on first REQ cycle
        io_txn(32'hFFFF_FC70, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h7777_7777, 1);
        chk("lit_wr_stalls", 32'(stall_cnt), 32'd2);
        chk("lit_wr_data", done_rdata, 32'h0);
        chk("lit_wr_wdata", io_wdata, 32'hDEAD_BEEF);
        chk("lit_wr_we", 32'(io_we), 32'h1);

        // Read and write both high counts as a write
        io_txn(32'hFFFF_FC04, 1'b1, 1'b1, 32'h0102_0304, 32'h9999_9999, 2);

        // Ack on the last permitted REQ cycle
        io_txn(32'hFFFF_FC08, 1'b0, 1'b0, 32'h0, 32'h1357_2468, 15);
        chk("lit_ack15_data", done_rdata, 32'h1357_2468);
        chk("lit_ack15_to", 32'(io_timeout), 32'h0);
        chk("lit_ack15_stalls", 32'(stall_cnt), 32'd16);

        // Timeout
        io_txn(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        chk("lit_to_data", done_rdata, 32'hFFFF_FFFF);
        chk("lit_to_flag", 32'(io_timeout), 32'h1);
        chk("lit_to_stalls", 32'(stall_cnt), 32'd16);

        // Timeout flag is sticky across a successful access
        io_txn(32'hFFFF_FC00, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 2);
        chk("lit_sticky_to", 32'(io_timeout), 32'h1);
        chk("lit_sticky_data", done_rdata, 32'hCAFE_F00D);

        // Stray ack in IDLE is ignored
        ram_op(32'h0000_0020, 1'b1, 1'b0, 32'h0F0F_0F0F, 32'h0, 1'b1);
        ram_op(32'h0000_0020, 1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0, 1'b0);

        // Reset in the 2nd REQ cycle
        cyc();
        address = 32'hFFFF_FC40; mem_read = 1'b1; mem_write = 1'b0; io_ack = 1'b0;
        write_data = 32'h4444_4444;
        exp_stall = 1'b1; exp_ram_we = 1'b0; exp_io_req = 1'b0; exp_done = 1'b0;
        cyc();
        m_addr = 10'h040; m_we = 1'b0; m_wdata = 32'h4444_4444; exp_io_req = 1'b1;
        cyc();
        reset = 1'b1; mem_read = 1'b0;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_timeout = 1'b0;
        exp_stall = 1'b0; exp_io_req = 1'b0;
        #1;
        chk("lit_rst_req", 32'(io_req), 32'h0);
        chk("lit_rst_stall", 32'(stall), 32'h0);
        chk("lit_rst_to", 32'(io_timeout), 32'h0);
        cyc();
        reset = 1'b0;
        ram_op(32'h0000_0040, 1'b1, 1'b0, 32'h89AB_CDEF, 32'h0, 1'b0);
        #1;
        chk("lit_post_rst_rd", read_data, 32'h89AB_CDEF);
        chk("lit_post_rst_stall", 32'(stall), 32'h0);
        ram_op(32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
